alarm_clock: RTL and testbench
==============================

# alarm_clock

Time-of-day clock with a settable alarm. A seconds/minutes/hours counter advances once per `clk` rising edge, so `clk` is the 1 Hz time base. An alarm register holds a target time. `out` flags the second in which the running time equals the alarm time while the alarm is enabled. The block sits between the user controls (select/increment buttons, set switch, enable switch) and the display and buzzer logic.

## Interface
Parameters: none. Field widths are fixed: sec 6, min 6, hour 5.
- `clk` in 1: time base; one rising edge = one second; sole clock.
- `reset` in 1: asynchronous, active-high; clears time, alarm and edge-detect state.
- `set` in 1: 1 = set mode (time frozen; select/increment edit the time); 0 = run mode (time counts; select/increment edit the alarm).
- `enable` in 1: alarm enable; gates `out`.
- `select` in 2: field to edit: `SELECT_NONE`=0, `SELECT_SEC`=1, `SELECT_MIN`=2, `SELECT_HOUR`=3.
- `increment` in 1: level input; each 0→1 transition adds 1 to the selected field.
- `sec_out` out 6, `min_out` out 6, `hour_out` out 5: current time.
- `alarm_sec_out` out 6, `alarm_min_out` out 6, `alarm_hour_out` out 5: alarm time.
- `out` out 1: alarm active.

## Operation
- Time counter, run mode (`set`=0):
  - sec +1 per clk; at 59 it wraps to 0 and min +1.
  - min at 59 with a sec carry wraps to 0 and hour +1.
  - hour at 23 with a min carry wraps to 0 (23:59:59 → 00:00:00).
- Time counter, set mode (`set`=1): counting frozen. An increment edge adds 1 to the selected time field modulo its range (sec/min 60, hour 24). No carry into the next field.
- Alarm register: an increment edge with `set`=0 adds 1 to the selected alarm field modulo its range, with no carry. The alarm never self-advances.
- `SELECT_NONE`: increment edges are ignored; nothing changes.
- Edge detect:
  - `inc_q` is `increment` registered on clk; reset value 0.
  - An edge is `increment & ~inc_q`, sampled at a clk rising edge.
  - Holding `increment` high produces exactly one increment.
  - A pulse that never overlaps a clk rising edge is missed. Inputs must be held at least one clk period.
- `select` is sampled at the same clk edge as the increment edge.
- `out` = `enable` AND (sec, min, hour) == (alarm sec, min, hour). It is combinational from registered state, so it is glitch-free with respect to inputs other than `enable`.
- Run mode and an alarm edit in the same cycle: both take effect; they touch independent registers.

## Timing
- Reset (async assert, synchronous-safe release):
  - all outputs, time registers and alarm registers are 0; `inc_q` = 0.
  - `out` = `enable` (times match at 00:00:00).
- Time update latency: the new value is visible right after the clk rising edge.
- Increment latency: the field updates at the first clk rising edge where `increment`=1 and `inc_q`=0.
- `out` asserts in the same cycle the times become equal. It stays high for exactly one clk period in run mode. In set mode it stays high while the times remain equal.
- Toggling `enable` affects `out` immediately (combinational).
- `set` 1→0: counting resumes at the next clk edge from the frozen value.

## Structure
- Package `alarm_clock_pkg`:
  - `SELECT_NONE/SEC/MIN/HOUR` (2-bit).
  - `SEC_W`=6, `MIN_W`=6, `HOUR_W`=5.
  - `SEC_MAX`=59, `MIN_MAX`=59, `HOUR_MAX`=23.
- Sub-module `hms_counter`, instantiated twice (time with `tick`=~set, alarm with `tick`=0):
  - Ports: clk, reset, tick, inc_sec, inc_min, inc_hour, sec, min, hour.
  - `tick` advances with carry.
  - `inc_*` add 1 to one field with no carry.
  - If `tick` and `inc_*` are both asserted, `tick` takes priority.
- The top holds the edge detector, select decode/routing, and the comparator.

## Test plan
- Reset, then increment edge with `SELECT_NONE`: time and alarm unchanged; alarm stays 00:00:00.
- Run mode, `SELECT_SEC`, two increment pulses (each held 1 clk): alarm = 00:00:02. Reset clock state to 0, `enable`=1: `out`=1 for exactly the one cycle when time = 00:00:02, else 0.
- Same match with `enable`=0: `out` stays 0.
- `increment` held high for 5 clks with `SELECT_MIN`: alarm min +1 only.
- Wrap: set mode, edit time to 23:59:59, then `set`=0 and one clk: time 00:00:00. Set mode, sec 59 plus an increment edge: sec 0, min unchanged.
- Alarm hour at 23 plus an increment edge: hour 0. Async reset asserted mid-count between clk edges: all outputs 0 immediately.

Source files
------------

// File: rtl/alarm_clock_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_clock_pkg
//  Description : Shared field widths, limits and select codes for alarm_clock.
//  Revision    : 1.0 - initial release
// ============================================================================
package alarm_clock_pkg;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

    localparam logic [1:0] SELECT_NONE = 2'd0;
    localparam logic [1:0] SELECT_SEC  = 2'd1;
    localparam logic [1:0] SELECT_MIN  = 2'd2;
    localparam logic [1:0] SELECT_HOUR = 2'd3;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  min;
        logic [SEC_W-1:0]  sec;
    } hms_t;

endpackage : alarm_clock_pkg
`default_nettype wire

// File: rtl/alarm_clock_hms_counter.sv
`default_nettype none
// ============================================================================
//  Module      : hms_counter
//  Description : Hours/minutes/seconds register with carrying tick and
//                per-field no-carry increments (tick has priority).
//  Revision    : 1.0 - initial release
// ============================================================================
module hms_counter
    import alarm_clock_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              inc_sec,
    input  logic              inc_min,
    input  logic              inc_hour,
    output logic [SEC_W-1:0]  sec,
    output logic [MIN_W-1:0]  min,
    output logic [HOUR_W-1:0] hour
);

    logic [SEC_W-1:0]  r_sec;
    logic [MIN_W-1:0]  r_min;
    logic [HOUR_W-1:0] r_hour;

    logic              w_sec_wrap;
    logic              w_min_wrap;
    logic              w_hour_wrap;
    logic [SEC_W-1:0]  w_sec_inc;
    logic [MIN_W-1:0]  w_min_inc;
    logic [HOUR_W-1:0] w_hour_inc;

    // Modulo successors shared by the carry chain and the field edits.
    assign w_sec_wrap  = (r_sec  >= SEC_MAX);
    assign w_min_wrap  = (r_min  >= MIN_MAX);
    assign w_hour_wrap = (r_hour >= HOUR_MAX);
    assign w_sec_inc   = w_sec_wrap  ? '0 : r_sec  + 1'b1;
    assign w_min_inc   = w_min_wrap  ? '0 : r_min  + 1'b1;
    assign w_hour_inc  = w_hour_wrap ? '0 : r_hour + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sec  <= '0;
            r_min  <= '0;
            r_hour <= '0;
        end else if (tick) begin
            r_sec <= w_sec_inc;
            if (w_sec_wrap) begin
                r_min <= w_min_inc;
                if (w_min_wrap) begin
                    r_hour <= w_hour_inc;
                end
            end
        end else begin
            if (inc_sec) begin
                r_sec <= w_sec_inc;
            end
            if (inc_min) begin
                r_min <= w_min_inc;
            end
            if (inc_hour) begin
                r_hour <= w_hour_inc;
            end
        end
    end

    assign sec  = r_sec;
    assign min  = r_min;
    assign hour = r_hour;

endmodule : hms_counter
`default_nettype wire

// File: rtl/alarm_clock.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_clock
//  Description : 1 Hz time-of-day clock with settable alarm, increment edge
//                detector, field select routing and alarm comparator.
//  Revision    : 1.0 - initial release
// ============================================================================
module alarm_clock
    import alarm_clock_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              set,
    input  logic              enable,
    input  logic [1:0]        select,
    input  logic              increment,
    output logic [SEC_W-1:0]  sec_out,
    output logic [MIN_W-1:0]  min_out,
    output logic [HOUR_W-1:0] hour_out,
    output logic [SEC_W-1:0]  alarm_sec_out,
    output logic [MIN_W-1:0]  alarm_min_out,
    output logic [HOUR_W-1:0] alarm_hour_out,
    output logic              out
);

    logic r_inc_q;
    logic w_inc_edge;
    logic w_sel_sec;
    logic w_sel_min;
    logic w_sel_hour;
    hms_t w_time;
    hms_t w_alarm;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inc_q <= 1'b0;
        end else begin
            r_inc_q <= increment;
        end
    end

    assign w_inc_edge = increment & ~r_inc_q;

    // SELECT_NONE decodes to no field, so its edges fall away here.
    assign w_sel_sec  = w_inc_edge & (select == SELECT_SEC);
    assign w_sel_min  = w_inc_edge & (select == SELECT_MIN);
    assign w_sel_hour = w_inc_edge & (select == SELECT_HOUR);

    hms_counter u_time (
        .clk      (clk),
        .reset    (reset),
        .tick     (~set),
        .inc_sec  (w_sel_sec  & set),
        .inc_min  (w_sel_min  & set),
        .inc_hour (w_sel_hour & set),
        .sec      (w_time.sec),
        .min      (w_time.min),
        .hour     (w_time.hour)
    );

    hms_counter u_alarm (
        .clk      (clk),
        .reset    (reset),
        .tick     (1'b0),
        .inc_sec  (w_sel_sec  & ~set),
        .inc_min  (w_sel_min  & ~set),
        .inc_hour (w_sel_hour & ~set),
        .sec      (w_alarm.sec),
        .min      (w_alarm.min),
        .hour     (w_alarm.hour)
    );

    assign sec_out        = w_time.sec;
    assign min_out        = w_time.min;
    assign hour_out       = w_time.hour;
    assign alarm_sec_out  = w_alarm.sec;
    assign alarm_min_out  = w_alarm.min;
    assign alarm_hour_out = w_alarm.hour;

    assign out = enable & (w_time == w_alarm);

endmodule : alarm_clock
`default_nettype wire

// File: tb/tb_alarm_clock.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alarm_clock
//  Description : Directed self-checking bench for alarm_clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_clock;
    import alarm_clock_pkg::*;

    logic              clk;
    logic              reset;
    logic              set;
    logic              enable;
    logic [1:0]        select;
    logic              increment;
    logic [SEC_W-1:0]  sec_out;
    logic [MIN_W-1:0]  min_out;
    logic [HOUR_W-1:0] hour_out;
    logic [SEC_W-1:0]  alarm_sec_out;
    logic [MIN_W-1:0]  alarm_min_out;
    logic [HOUR_W-1:0] alarm_hour_out;
    logic              out;

    int checks;
    int failures;

    alarm_clock u_dut (
        .clk            (clk),
        .reset          (reset),
        .set            (set),
        .enable         (enable),
        .select         (select),
        .increment      (increment),
        .sec_out        (sec_out),
        .min_out        (min_out),
        .hour_out       (hour_out),
        .alarm_sec_out  (alarm_sec_out),
        .alarm_min_out  (alarm_min_out),
        .alarm_hour_out (alarm_hour_out),
        .out            (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int n);
        for (int i = 0; i < n; i++) begin
            increment = 1'b1;
            step();
            increment = 1'b0;
            step();
        end
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s);
        check({tag, ".hour"}, hour_out, h);
        check({tag, ".min"},  min_out,  m);
        check({tag, ".sec"},  sec_out,  s);
    endtask

    task automatic check_alarm(input string tag, input int h, input int m, input int s);
        check({tag, ".ahour"}, alarm_hour_out, h);
        check({tag, ".amin"},  alarm_min_out,  m);
        check({tag, ".asec"},  alarm_sec_out,  s);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        set       = 1'b1;
        enable    = 1'b0;
        select    = SELECT_NONE;
        increment = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();

        // Reset state; times match at 00:00:00 so out follows enable
        check_time("rst", 0, 0, 0);
        check_alarm("rst", 0, 0, 0);
        check("rst.out_en0", out, 0);
        enable = 1'b1;
        #1;
        check("rst.out_en1", out, 1);
        enable = 1'b0;

        // SELECT_NONE edges change nothing in either mode
        pulse(1);
        check_time("none_set", 0, 0, 0);
        check_alarm("none_set", 0, 0, 0);
        set = 1'b0;
        pulse(1);
        check_alarm("none_run", 0, 0, 0);

        // Alarm sec +2 in run mode; time has run 6 clocks in total
        select = SELECT_SEC;
        pulse(2);
        set = 1'b1;
        check_alarm("alarm2", 0, 0, 2);
        check_time("run6", 0, 0, 6);

        // Set mode: edit time to 23:59:59 (sec 6->59, min 0->59, hour 0->23)
        pulse(53);
        select = SELECT_MIN;
        pulse(59);
        select = SELECT_HOUR;
        pulse(23);
        check_time("set235959", 23, 59, 59);
        check_alarm("set_keeps_alarm", 0, 0, 2);
        enable = 1'b1;
        #1;
        check("nomatch.out", out, 0);

        // Run: wrap to midnight, out high only at 00:00:02
        set    = 1'b0;
        select = SELECT_NONE;
        step();
        check_time("wrap", 0, 0, 0);
        check("t0.out", out, 0);
        step();
        check("t1.out", out, 0);
        step();
        check_time("t2", 0, 0, 2);
        check("t2.out", out, 1);
        step();
        check("t3.out", out, 0);

        // Set mode match: sec 3 -> 2 via 59 edges, out held while equal
        set    = 1'b1;
        select = SELECT_SEC;
        pulse(59);
        check_time("setmatch", 0, 0, 2);
        check("setmatch.out", out, 1);
        step();
        check("setmatch.hold", out, 1);
        enable = 1'b0;
        #1;
        check("setmatch.en0", out, 0);

        // Set mode sec 59 + edge: sec wraps, min untouched
        pulse(57);
        check("sec59", sec_out, 59);
        pulse(1);
        check_time("secwrap", 0, 0, 0);

        // Held increment yields exactly one alarm minute step
        set       = 1'b0;
        select    = SELECT_MIN;
        increment = 1'b1;
        for (int i = 0; i < 5; i++) step();
        increment = 1'b0;
        step();
        check_alarm("held", 0, 1, 2);

        // Alarm hour 23 then wrap
        select = SELECT_HOUR;
        pulse(23);
        check("ahour23", alarm_hour_out, 23);
        pulse(1);
        check_alarm("ahourwrap", 0, 1, 2);

        // Asynchronous reset between clock edges
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_time("async", 0, 0, 0);
        check_alarm("async", 0, 0, 0);
        check("async.out", out, 0);
        step();
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_alarm_clock
`default_nettype wire
